// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a five-stage-style multicycle RISC-V datapath.
// The FSM sequences fetch, decode, execute, memory and writeback. A wait counter
// halts the machine with a sticky Error if a memory access stalls too long.
// Optional build macro ILLEGAL_TRAP_EN: when defined, an illegal opcode halts the
// machine with Error=1. When undefined (default), an illegal opcode retires as a NOP.
module multicycle_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [31:0] Instruction,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PcWrite,
    output logic        PcSrc,
    output logic        IrWrite,
    output logic        InsMemRead,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        AluSrc,
    output logic        Busy,
    output logic        Error,
    output logic [1:0]  AluOp,
    output logic [2:0]  State,
    output logic [31:0] InstrCount
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    state_t              r_state;
    state_t              w_state_next;
    logic [6:0]          r_opcode;
    logic [6:0]          w_opcode_next;
    logic [WAIT_W-1:0]   r_wait;
    logic [WAIT_W-1:0]   w_wait_next;
    logic [WAIT_W-1:0]   w_wait_inc;
    logic [31:0]         r_instr_count;
    logic                r_error;
    logic                w_error_set;
    logic                w_is_r;
    logic                w_is_ld;
    logic                w_is_sd;
    logic                w_is_beq;
    logic                w_is_addi;
    logic                w_legal;
    logic                w_unused_instr;

    // Only the opcode field is decoded; the rest of the word is for the datapath.
    assign w_unused_instr = ^Instruction[31:7];

    assign w_is_r    = (r_opcode == OP_R);
    assign w_is_ld   = (r_opcode == OP_LD);
    assign w_is_sd   = (r_opcode == OP_SD);
    assign w_is_beq  = (r_opcode == OP_BEQ);
    assign w_is_addi = (r_opcode == OP_ADDI);
    assign w_legal   = w_is_r | w_is_ld | w_is_sd | w_is_beq | w_is_addi;

    assign w_wait_inc = r_wait + 1'b1;

    assign State      = r_state;
    assign Error      = r_error;
    assign InstrCount = r_instr_count;

    // Next-state and control decode; IrWrite and the MEM/FETCH exits are Mealy on MemReady.
    always_comb begin
        w_state_next  = r_state;
        w_opcode_next = r_opcode;
        w_wait_next   = '0;
        w_error_set   = 1'b0;
        PcWrite       = 1'b0;
        PcSrc         = 1'b0;
        IrWrite       = 1'b0;
        InsMemRead    = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        MemtoReg      = 1'b0;
        RegWrite      = 1'b0;
        AluSrc        = 1'b0;
        Busy          = 1'b0;
        AluOp         = 2'b00;

        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_state_next = S_FETCH;
                end
            end

            S_FETCH: begin
                Busy       = 1'b1;
                InsMemRead = 1'b1;
                IrWrite    = MemReady;
                if (MemReady) begin
                    w_opcode_next = Instruction[6:0];
                    w_state_next  = S_DECODE;
                end else begin
                    w_wait_next = w_wait_inc;
                    if (w_wait_inc == WAIT_LIMIT) begin
                        w_state_next = S_HALT;
                        w_error_set  = 1'b1;
                    end
                end
            end

            S_DECODE: begin
                Busy = 1'b1;
                if (w_legal) begin
                    w_state_next = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    w_state_next = S_HALT;
                    w_error_set  = 1'b1;
`else
                    // Illegal opcode retires as a NOP: advance PC to PC+4.
                    PcWrite      = 1'b1;
                    w_state_next = S_FETCH;
`endif
                end
            end

            S_EXEC: begin
                Busy   = 1'b1;
                AluSrc = w_is_ld | w_is_sd | w_is_addi;
                if (w_is_beq) begin
                    AluOp = 2'b01;
                end else if (w_is_r | w_is_addi) begin
                    AluOp = 2'b10;
                end else begin
                    AluOp = 2'b00;
                end

                if (w_is_r | w_is_addi) begin
                    w_state_next = S_WB;
                end else if (w_is_ld | w_is_sd) begin
                    w_state_next = S_MEM;
                end else begin
                    // beq resolves here; any unexpected opcode also just advances.
                    PcWrite      = 1'b1;
                    PcSrc        = w_is_beq & Zero;
                    w_state_next = S_FETCH;
                end
            end

            S_MEM: begin
                Busy     = 1'b1;
                MemRead  = w_is_ld;
                MemWrite = w_is_sd;
                if (MemReady) begin
                    if (w_is_ld) begin
                        w_state_next = S_WB;
                    end else begin
                        PcWrite      = 1'b1;
                        w_state_next = S_FETCH;
                    end
                end else begin
                    w_wait_next = w_wait_inc;
                    if (w_wait_inc == WAIT_LIMIT) begin
                        w_state_next = S_HALT;
                        w_error_set  = 1'b1;
                    end
                end
            end

            S_WB: begin
                Busy         = 1'b1;
                RegWrite     = 1'b1;
                MemtoReg     = w_is_ld;
                PcWrite      = 1'b1;
                w_state_next = S_FETCH;
            end

            S_HALT: begin
                w_state_next = S_HALT;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, opcode, wait counter, retire counter and sticky error registers.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state       <= S_IDLE;
            r_opcode      <= '0;
            r_wait        <= '0;
            r_instr_count <= '0;
            r_error       <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_opcode <= w_opcode_next;
            r_wait   <= w_wait_next;
            if (PcWrite) begin
                r_instr_count <= r_instr_count + 32'd1;
            end
            if (w_error_set) begin
                r_error <= 1'b1;
            end
        end
    end

endmodule
